// File: rtl/fpu_alu_pkg.sv
// Shared definitions for the FPU request scheduler.
//   DATA_W          : operand / result width (IEEE-754 single)
//   OP_ADD..OP_DIV  : opcode encoding carried on reqN_op / alu_op
//   state_t         : scheduler FSM encoding (also visible on dbg_state)
package fpu_alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   i_valid0/1    : requester has a pending request
//   i_last_grant  : requester served most recently (0 or 1)
//   o_grant0/1    : one-hot (or zero) grant
// With both valid, the requester that was not served last wins; a lone
// valid requester always wins.
module fpu_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant0,
  output logic o_grant1
);

  assign o_grant0 = i_valid0 & (~i_valid1 | i_last_grant);
  assign o_grant1 = i_valid1 & (~i_valid0 | ~i_last_grant);

endmodule

// File: rtl/fpu_alu_arbiter.sv
// Shares one FP datapath (add/sub, mul, div) between two requesters.
// A request is accepted in IDLE, its operands are held on alu_* for the
// operation's settle latency (EXEC), then result/flags are captured and
// offered on the tagged response port (RESP) until taken.
//
// Ports:
//   clk, reset_n               : clock, async active-low reset
//   reqN_valid/ready/op/a/b    : request ports, N = 0,1
//   alu_a/b/op/addsub/control  : datapath drive (control high only in EXEC)
//   alu_result/exception/zerodiv : datapath outputs
//   rsp_valid/ready/id/data/exception/zerodiv : response port
//   busy                       : scheduler not idle
//   perf_ops, perf_exc         : statistics (FPU_ALU_ARBITER_PERF_EN)
//   dbg_state                  : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters keep op/a/b stable while valid; ready is high only
// in IDLE and only for the granted requester. rsp_* stays stable while
// rsp_valid is high and rsp_ready is low.
//
// Build option: define FPU_ALU_ARBITER_PERF_EN to build the saturating
// perf_ops / perf_exc counters; otherwise both read 0 with no flops.
module fpu_alu_arbiter
  import fpu_alu_pkg::*;
#(
  parameter int ADDSUB_LAT = 2,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 6,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  output logic              alu_addsub,
  output logic              alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_exception,
  input  logic              alu_zerodiv,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_exception,
  output logic              rsp_zerodiv,
  output logic              busy,
  output logic [15:0]       perf_ops,
  output logic [15:0]       perf_exc,
  output logic [1:0]        dbg_state
);

  state_t              r_state, w_next_state;
  logic                r_last_grant;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b;
  logic                r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_exc, r_rsp_zdiv;

  logic                w_gnt0, w_gnt1, w_accept, w_acc_id, w_rsp_hs;
  logic [1:0]          w_acc_op;

  // Counter is loaded with LAT-1 so the capture edge lands LAT cycles
  // after the accepting edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      OP_MUL:  lat_m1 = CNT_W'(MUL_LAT - 1);
      OP_DIV:  lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(ADDSUB_LAT - 1);
    endcase
  endfunction

  fpu_rr_arb2 u_arb (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant0     (w_gnt0),
    .o_grant1     (w_gnt1)
  );

  assign w_accept = (r_state == ST_IDLE) & (w_gnt0 | w_gnt1);
  assign w_acc_id = w_gnt1;
  assign w_acc_op = w_gnt1 ? req1_op : req0_op;
  assign w_rsp_hs = (r_state == ST_RESP) & rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    alu_control  = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        if (w_gnt0 | w_gnt1) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        alu_control = 1'b1;
        if (r_cnt == '0) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (w_rsp_hs) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request capture, latency countdown and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_exc    <= 1'b0;
      r_rsp_zdiv   <= 1'b0;
    end else if (w_accept) begin
      r_op         <= w_acc_op;
      r_a          <= w_gnt1 ? req1_a : req0_a;
      r_b          <= w_gnt1 ? req1_b : req0_b;
      r_id         <= w_acc_id;
      r_last_grant <= w_acc_id;
      r_cnt        <= lat_m1(w_acc_op);
    end else if (r_state == ST_EXEC) begin
      if (r_cnt == '0) begin
        r_rsp_id   <= r_id;
        r_rsp_data <= alu_result;
        r_rsp_exc  <= alu_exception;
        // Only the divider owns the zero-divide flag.
        r_rsp_zdiv <= (r_op == OP_DIV) & alu_zerodiv;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_op        = r_op;
  assign alu_addsub    = ~r_op[1] & r_op[0];
  assign rsp_id        = r_rsp_id;
  assign rsp_data      = r_rsp_data;
  assign rsp_exception = r_rsp_exc;
  assign rsp_zerodiv   = r_rsp_zdiv;
  assign dbg_state     = r_state;

`ifdef FPU_ALU_ARBITER_PERF_EN
  logic [15:0] r_perf_ops, r_perf_exc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_ops <= '0;
      r_perf_exc <= '0;
    end else if (w_rsp_hs) begin
      if (r_perf_ops != 16'hFFFF) r_perf_ops <= r_perf_ops + 16'd1;
      if ((r_rsp_exc | r_rsp_zdiv) && (r_perf_exc != 16'hFFFF))
        r_perf_exc <= r_perf_exc + 16'd1;
    end
  end

  assign perf_ops = r_perf_ops;
  assign perf_exc = r_perf_exc;
`else
  assign perf_ops = '0;
  assign perf_exc = '0;
`endif

endmodule

// File: tb/tb_fpu_alu_arbiter.sv
module tb_fpu_alu_arbiter;

  localparam int ADDSUB_LAT = 2;
  localparam int MUL_LAT    = 3;
  localparam int DIV_LAT    = 6;

  logic        clk, reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op, alu_op, dbg_state;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic        alu_addsub, alu_control, alu_exception, alu_zerodiv;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_exception, rsp_zerodiv, busy;
  logic [15:0] perf_ops, perf_exc;

  int n_cmp = 0;
  int n_bad = 0;
  int seq   = 0;

  fpu_alu_arbiter #(
    .ADDSUB_LAT(ADDSUB_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_addsub(alu_addsub),
    .alu_control(alu_control), .alu_result(alu_result),
    .alu_exception(alu_exception), .alu_zerodiv(alu_zerodiv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_exception(rsp_exception), .rsp_zerodiv(rsp_zerodiv),
    .busy(busy), .perf_ops(perf_ops), .perf_exc(perf_exc), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: an operation is either pending (waiting out its
  // latency) or its response is waiting to be taken; otherwise idle.
  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b10:   return MUL_LAT;
      2'b11:   return DIV_LAT;
      default: return ADDSUB_LAT;
    endcase
  endfunction

  function automatic int pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  bit          m_pend = 0, m_rsp = 0;
  int          m_wait = 0, m_last = 1, m_id = 0, m_win;
  logic [1:0]  m_op = 0;
  logic [31:0] m_a = 0, m_b = 0, m_rdata = 0;
  logic        m_rid = 0, m_rexc = 0, m_rzd = 0;
  int          m_pops = 0, m_pexc = 0;

  always_comb m_win = pick(req0_valid, req1_valid, m_last);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend <= 0; m_rsp <= 0; m_wait <= 0; m_last <= 1; m_id <= 0;
      m_op <= 0; m_a <= 0; m_b <= 0;
      m_rid <= 0; m_rdata <= 0; m_rexc <= 0; m_rzd <= 0;
      m_pops <= 0; m_pexc <= 0;
    end else if (m_rsp) begin
      if (rsp_ready) begin
        m_rsp <= 0;
        if (m_pops < 65535) m_pops <= m_pops + 1;
        if ((m_rexc || m_rzd) && m_pexc < 65535) m_pexc <= m_pexc + 1;
      end
    end else if (m_pend) begin
      if (m_wait == 1) begin
        m_pend  <= 0;
        m_rsp   <= 1;
        m_rid   <= m_id[0];
        m_rdata <= alu_result;
        m_rexc  <= alu_exception;
        m_rzd   <= (m_op == 2'b11) ? alu_zerodiv : 1'b0;
      end else begin
        m_wait <= m_wait - 1;
      end
    end else if (m_win >= 0) begin
      m_pend <= 1;
      m_id   <= m_win;
      m_last <= m_win;
      m_op   <= (m_win == 1) ? req1_op : req0_op;
      m_a    <= (m_win == 1) ? req1_a : req0_a;
      m_b    <= (m_win == 1) ? req1_b : req0_b;
      m_wait <= lat_of((m_win == 1) ? req1_op : req0_op);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, (!m_pend && !m_rsp && m_win == 0)});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, (!m_pend && !m_rsp && m_win == 1)});
      chk("busy",       {31'd0, busy},        {31'd0, (m_pend || m_rsp)});
      chk("alu_control",{31'd0, alu_control}, {31'd0, m_pend});
      chk("rsp_valid",  {31'd0, rsp_valid},   {31'd0, m_rsp});
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", {30'd0, alu_op}, {30'd0, m_op});
      chk("alu_addsub", {31'd0, alu_addsub}, {31'd0, (m_op == 2'b01)});
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_rid});
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_exception", {31'd0, rsp_exception}, {31'd0, m_rexc});
      chk("rsp_zerodiv", {31'd0, rsp_zerodiv}, {31'd0, m_rzd});
`ifdef FPU_ALU_ARBITER_PERF_EN
      chk("perf_ops", {16'd0, perf_ops}, m_pops);
      chk("perf_exc", {16'd0, perf_exc}, m_pexc);
`else
      chk("perf_ops", {16'd0, perf_ops}, 32'd0);
      chk("perf_exc", {16'd0, perf_exc}, 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int order);
    bit done = 0;
    if (r == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    order = seq;
    seq++;
    chk("issue_accepted", {31'd0, done}, 32'd1);
  endtask

  // Returns at the negedge where rsp_valid is first seen; lat counts
  // rising edges since the accepting edge.
  task automatic wait_rsp(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("rsp_arrived", {31'd0, seen}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int lat, o0, o1;
  logic [31:0] snap;

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    alu_result = 0; alu_exception = 0; alu_zerodiv = 0;
    #1 cmp_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    step();
    reset_n = 1'b1;

    // Simultaneous mul pair from reset: req0 first, then req1.
    alu_result = 32'h40C00000;
    seq = 0;
    fork
      issue(0, 2'b10, 32'h40000000, 32'h40400000, o0);
      issue(1, 2'b10, 32'h3F800000, 32'h40C00000, o1);
    join
    chk("pair1_req0_first", o0, 32'd0);
    chk("pair1_req1_second", o1, 32'd1);
    wait_rsp(lat);
    chk("mul_latency", lat, MUL_LAT);
    chk("mul_rsp_id", {31'd0, rsp_id}, 32'd1);
    step();

    // Solo add 1.0 + 2.0 = 3.0.
    alu_result = 32'h40400000;
    issue(0, 2'b00, 32'h3F800000, 32'h40000000, o0);
    wait_rsp(lat);
    chk("add_latency", lat, 2);
    chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("add_rsp_data", rsp_data, 32'h40400000);
    chk("add_rsp_exc", {31'd0, rsp_exception}, 32'd0);
    step();

    // req0 served last, so the next simultaneous pair goes to req1 first.
    seq = 0;
    fork
      issue(0, 2'b01, 32'h40400000, 32'h3F800000, o0);
      issue(1, 2'b00, 32'h40000000, 32'h40000000, o1);
    join
    chk("pair2_req1_first", o1, 32'd0);
    chk("pair2_req0_second", o0, 32'd1);
    wait_rsp(lat);
    step();

    // Divide by zero from req1, then an add with the zerodiv line still high.
    alu_result = 32'h7F800000; alu_zerodiv = 1'b1;
    issue(1, 2'b11, 32'h3F800000, 32'h00000000, o1);
    wait_rsp(lat);
    chk("div_latency", lat, 6);
    chk("div_zerodiv", {31'd0, rsp_zerodiv}, 32'd1);
    chk("div_rsp_id", {31'd0, rsp_id}, 32'd1);
    step();
    alu_result = 32'h40400000;
    issue(0, 2'b00, 32'h3F800000, 32'h40000000, o0);
    wait_rsp(lat);
    chk("add_after_div_zerodiv", {31'd0, rsp_zerodiv}, 32'd0);
    step();
    alu_zerodiv = 1'b0;

    // Backpressure: response held 10 cycles with req1 waiting.
    rsp_ready = 1'b0;
    alu_result = 32'h3F000000;
    issue(0, 2'b01, 32'h3F800000, 32'h3F000000, o0);
    wait_rsp(lat);
    snap = rsp_data;
    chk("bp_data", snap, 32'h3F000000);
    req1_op = 2'b00; req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_data", rsp_data, 32'h3F000000);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", {31'd0, busy}, 32'd0);
    chk("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(lat);
    step();

    // Reset mid-EXEC of a divide aborts it.
    alu_result = 32'h3F800000; alu_zerodiv = 1'b1;
    issue(1, 2'b11, 32'h3F800000, 32'h00000000, o1);
    step();
    chk("midexec_control", {31'd0, alu_control}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_control", {31'd0, alu_control}, 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    alu_zerodiv = 1'b0;
    repeat (3) @(negedge clk) chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    step();
    seq = 0;
    fork
      issue(0, 2'b00, 32'h3F800000, 32'h3F800000, o0);
      issue(1, 2'b00, 32'h40000000, 32'h3F800000, o1);
    join
    chk("post_reset_req0_first", o0, 32'd0);
    wait_rsp(lat);
    step();

    // Statistics: three ops, one with an overflow exception.
    do_reset();
    alu_result = 32'h40400000; alu_exception = 1'b0;
    issue(0, 2'b00, 32'h3F800000, 32'h40000000, o0);
    wait_rsp(lat); step();
    alu_result = 32'h7F800000; alu_exception = 1'b1;
    issue(1, 2'b10, 32'h7F000000, 32'h7F000000, o1);
    wait_rsp(lat); step();
    alu_result = 32'h40000000; alu_exception = 1'b0;
    issue(0, 2'b00, 32'h3F800000, 32'h3F800000, o0);
    wait_rsp(lat); step();
    @(negedge clk);
`ifdef FPU_ALU_ARBITER_PERF_EN
    chk("perf_ops_final", {16'd0, perf_ops}, 32'd3);
    chk("perf_exc_final", {16'd0, perf_exc}, 32'd1);
`else
    chk("perf_ops_final", {16'd0, perf_ops}, 32'd0);
    chk("perf_exc_final", {16'd0, perf_exc}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
